vcache_req_arbiter: RTL and testbench
=====================================

Name: vcache_req_arbiter

Overview:
- Shares one vcache port among num_req_p requesters (tiles or DMA engines).
- Each cycle, grants at most one valid cache packet using round-robin priority.
- Records the granted requester's ID in an in-order ID FIFO.
- Steers each returning cache response to the requester at the FIFO head, relying on the vcache's in-order response guarantee.
- Sits between the requester side of the network and the vcache's v_i/ready_o and v_o/yumi_i interfaces.

Parameters:
- num_req_p, 4, number of requesters; must be at least 2.
- cache_pkt_width_p, 64, width of the packed bsg_cache packet.
- data_width_p, 32, response data width.
- id_fifo_els_p, 4, maximum number of outstanding granted requests; must be a power of 2, at least 2.
- lg_num_req_lp, derived as clog2(num_req_p), requester ID width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  num_req_p  per-requester packet valid.
- req_pkt_i  in  num_req_p*cache_pkt_width_p  per-requester packets; requester k occupies slice k.
- req_ready_o  out  num_req_p  one-hot grant; the packet is accepted in the cycle where req_v_i[k] and req_ready_o[k] are both high.
- cache_v_o  out  1  packet valid to vcache (drives the vcache's v_i).
- cache_pkt_o  out  cache_pkt_width_p  granted packet.
- cache_ready_i  in  1  vcache ready_o.
- cache_v_i  in  1  vcache response valid (the vcache's v_o).
- cache_data_i  in  data_width_p  vcache response data.
- cache_yumi_o  out  1  response consumed (drives the vcache's yumi_i).
- resp_v_o  out  num_req_p  one-hot response valid.
- resp_data_o  out  data_width_p  response data, broadcast to all requesters.
- resp_yumi_i  in  num_req_p  per-requester response accept.
- grant_count_o  out  num_req_p*32  per-requester grant counters (see Optional Feature).

Behaviour:
- Reset (sync, active-high): rr_ptr=0; FIFO empty (rd_ptr=wr_ptr=0, count=0).
  - All outputs 0: req_ready_o, cache_v_o, cache_yumi_o, resp_v_o, grant_count_o.
  - cache_pkt_o and resp_data_o are don't-care.
  - Reset applied with requests in flight drops all FIFO state; the bench reset also resets the vcache.
- Arbitration is combinational, with zero-cycle latency from request to cache:
  - can_issue = cache_ready_i & (count != id_fifo_els_p).
  - Winner = first k with req_v_i[k]=1, searching from rr_ptr upward with wrap-around modulo num_req_p.
  - If can_issue and a winner exists: req_ready_o[winner]=1, cache_v_o=1, cache_pkt_o = req_pkt_i slice winner, push winner ID.
  - Otherwise req_ready_o=0 and cache_v_o=0.
  - req_ready_o never depends on req_v_i of the same requester, except through winner selection.
- Round-robin update: on each grant, rr_ptr <= winner+1 (wraps to 0 after num_req_p-1). rr_ptr is unchanged when there is no grant.
- Full FIFO: no grant, even if a pop happens in the same cycle. Push is gated on the registered count only; this removes the combinational path from yumi to ready.
- Response path:
  - head = ID at rd_ptr.
  - resp_v_o[head] = cache_v_i & (count != 0); all other bits 0.
  - resp_data_o = cache_data_i.
  - cache_yumi_o = cache_v_i & (count != 0) & resp_yumi_i[head].
  - Pop on cache_yumi_o.
  - resp_yumi_i bits for non-head requesters are ignored.
- Simultaneous push and pop (FIFO not full): count is unchanged, both pointers advance.
- Pointer wrap: pointers are lg(id_fifo_els_p) bits wide and wrap naturally; count is lg(id_fifo_els_p)+1 bits.
- cache_v_i with count=0 is a protocol error: no resp_v_o, no yumi. Simulation fires $error("vcache_req_arbiter: response with empty ID FIFO").
- Simulation also asserts, on every cycle, that req_ready_o is onehot0 and resp_v_o is onehot0.

Optional Feature:
- Macro: VCACHE_REQ_ARBITER_STATS_EN.
- Defined:
  - Per-requester 32-bit counter, incremented on each grant to that requester.
  - Saturates at 0xFFFF_FFFF.
  - Reset to 0 by reset_i.
  - Driven onto grant_count_o slice k.
- Undefined: no counters are built and grant_count_o is tied to 0.

Test Plan:
- Reset, then all 4 req_v_i=1 held, cache_ready_i=1, id_fifo_els_p=4, and each response returned with resp_yumi_i=1 one cycle after its grant -> grants go to 0,1,2,3,0,1 in consecutive cycles; each response is routed to the matching requester. With the macro defined, grant_count_o reads 2,2,1,1 after 6 grants.
- Only requester 2 valid, cache never returns data -> 4 grants on cycles 0-3; req_ready_o=0 from cycle 4 onward. Returning one response with resp_yumi_i[2]=1 -> one further grant in the following cycle.
- FIFO full (count=4), cache_v_i=1 with head accepted, requester 1 valid in the same cycle -> no grant that cycle; grant to requester 1 on the next cycle; count goes 4 -> 3 -> 4.
- Issue order 3,0,1; responses D0=0xA, D1=0xB, D2=0xC; resp_yumi_i[3] held low for 3 cycles -> resp_v_o=4'b1000 held stable with data 0xA and cache_yumi_o=0. Once yumi is raised, 0xB goes to requester 0 and 0xC to requester 1.
- cache_ready_i=0 with all requests valid -> req_ready_o=0, cache_v_o=0, and rr_ptr holds. Raising cache_ready_i grants the requester at the held rr_ptr first.
- reset_i asserted mid-stream with 3 requests outstanding -> next cycle count=0, rr_ptr=0, all outputs 0. The first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/vcache_req_arbiter.sv
// ============================================================================
// vcache_req_arbiter
//
// Purpose:
//   Shares a single vcache port among num_req_p requesters. Each cycle at most
//   one valid packet is granted using round-robin priority, and the granted
//   requester ID is recorded in an in-order ID FIFO. Because the vcache returns
//   responses in order, each response is steered to the requester whose ID is
//   at the FIFO head.
//
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   req_v_i            per-requester packet valid
//   req_pkt_i          per-requester packets, requester k in slice k
//   req_ready_o        one-hot grant (accept when req_v_i[k] & req_ready_o[k])
//   cache_v_o          packet valid to the vcache (vcache v_i)
//   cache_pkt_o        granted packet
//   cache_ready_i      vcache ready_o
//   cache_v_i          vcache response valid (vcache v_o)
//   cache_data_i       vcache response data
//   cache_yumi_o       response consumed (vcache yumi_i)
//   resp_v_o           one-hot response valid
//   resp_data_o        response data, broadcast to all requesters
//   resp_yumi_i        per-requester response accept (only the head's bit matters)
//   grant_count_o      per-requester 32-bit grant counters, requester k in slice k
//
// Configuration:
//   VCACHE_REQ_ARBITER_STATS_EN  when defined, builds saturating per-requester
//                                grant counters; otherwise grant_count_o is 0.
// ============================================================================
module vcache_req_arbiter #(
    parameter int num_req_p         = 4,
    parameter int cache_pkt_width_p = 64,
    parameter int data_width_p      = 32,
    parameter int id_fifo_els_p     = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_req_p-1:0]                   req_v_i,
    input  logic [num_req_p*cache_pkt_width_p-1:0] req_pkt_i,
    output logic [num_req_p-1:0]                   req_ready_o,
    output logic                                   cache_v_o,
    output logic [cache_pkt_width_p-1:0]           cache_pkt_o,
    input  logic                                   cache_ready_i,
    input  logic                                   cache_v_i,
    input  logic [data_width_p-1:0]                cache_data_i,
    output logic                                   cache_yumi_o,
    output logic [num_req_p-1:0]                   resp_v_o,
    output logic [data_width_p-1:0]                resp_data_o,
    input  logic [num_req_p-1:0]                   resp_yumi_i,
    output logic [num_req_p*32-1:0]                grant_count_o
);

    localparam int lg_num_req_lp = $clog2(num_req_p);
    localparam int lg_fifo_els_lp = $clog2(id_fifo_els_p);
    localparam logic [lg_fifo_els_lp:0] fifo_full_lp = (lg_fifo_els_lp+1)'(id_fifo_els_p);

    typedef logic [lg_num_req_lp-1:0]  id_t;
    typedef logic [lg_fifo_els_lp-1:0] ptr_t;
    typedef logic [lg_fifo_els_lp:0]   cnt_t;

    id_t  rr_ptr_q, rr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    cnt_t count_q, count_d;
    id_t  id_mem_q [id_fifo_els_p];
    id_t  id_mem_d [id_fifo_els_p];

    logic [cache_pkt_width_p-1:0] req_pkt_arr [num_req_p];

    id_t  winner;
    id_t  cand;
    logic found;
    logic can_issue;
    logic grant;
    id_t  head;
    logic resp_ok;
    logic pop;

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign req_pkt_arr[g] = req_pkt_i[g*cache_pkt_width_p +: cache_pkt_width_p];
    end

    // Round-robin winner search starting at rr_ptr_q. Push is gated on the
    // registered count only, so a same-cycle pop never opens a slot; this keeps
    // resp_yumi_i out of the combinational path to req_ready_o.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = id_t'((int'(rr_ptr_q) + i) % num_req_p);
            if (!found && req_v_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        can_issue   = cache_ready_i && (count_q != fifo_full_lp);
        grant       = can_issue && found;
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[winner] = 1'b1;
        end
        cache_v_o   = grant;
        cache_pkt_o = req_pkt_arr[winner];
    end

    // Response steering: the FIFO head names the requester owning the
    // in-order response. A response with an empty FIFO is dropped.
    always_comb begin
        head         = id_mem_q[rd_ptr_q];
        resp_ok      = cache_v_i && (count_q != '0);
        resp_v_o     = '0;
        if (resp_ok) begin
            resp_v_o[head] = 1'b1;
        end
        resp_data_o  = cache_data_i;
        cache_yumi_o = resp_ok && resp_yumi_i[head];
        pop          = cache_yumi_o;
    end

    // Next-state for the round-robin pointer and ID FIFO.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        id_mem_d = id_mem_q;
        if (grant) begin
            rr_ptr_d = (winner == id_t'(num_req_p-1)) ? '0 : winner + 1'b1;
            id_mem_d[wr_ptr_q] = winner;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (grant && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!grant && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            id_mem_q <= '{default: '0};
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            id_mem_q <= id_mem_d;
        end
    end

`ifdef VCACHE_REQ_ARBITER_STATS_EN
    logic [31:0] grant_cnt_q [num_req_p];
    logic [31:0] grant_cnt_d [num_req_p];

    // Saturating per-requester grant counters.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (grant && (grant_cnt_q[winner] != 32'hFFFF_FFFF)) begin
            grant_cnt_d[winner] = grant_cnt_q[winner] + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grant_cnt_q <= '{default: '0};
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    for (genvar g = 0; g < num_req_p; g++) begin : g_stats
        assign grant_count_o[g*32 +: 32] = grant_cnt_q[g];
    end
`else
    assign grant_count_o = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert ($onehot0(req_ready_o))
                else $error("vcache_req_arbiter: req_ready_o not onehot0");
            assert ($onehot0(resp_v_o))
                else $error("vcache_req_arbiter: resp_v_o not onehot0");
            if (cache_v_i && (count_q == '0)) begin
                $error("vcache_req_arbiter: response with empty ID FIFO");
            end
        end
    end
`endif

endmodule

// File: tb/tb_vcache_req_arbiter.sv
// ============================================================================
// tb_vcache_req_arbiter
//
// Drives the arbiter with directed scenarios followed by randomized traffic and
// compares every output against a behavioural model built from a queue of
// outstanding requester IDs and an integer round-robin pointer.
// ============================================================================
module tb_vcache_req_arbiter;

    localparam int N  = 4;
    localparam int PW = 64;
    localparam int DW = 32;
    localparam int FE = 4;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [N-1:0]      req_v_i;
    logic [N*PW-1:0]   req_pkt_i;
    logic [N-1:0]      req_ready_o;
    logic              cache_v_o;
    logic [PW-1:0]     cache_pkt_o;
    logic              cache_ready_i;
    logic              cache_v_i;
    logic [DW-1:0]     cache_data_i;
    logic              cache_yumi_o;
    logic [N-1:0]      resp_v_o;
    logic [DW-1:0]     resp_data_o;
    logic [N-1:0]      resp_yumi_i;
    logic [N*32-1:0]   grant_count_o;

    vcache_req_arbiter #(
        .num_req_p        (N),
        .cache_pkt_width_p(PW),
        .data_width_p     (DW),
        .id_fifo_els_p    (FE)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_v_i      (req_v_i),
        .req_pkt_i    (req_pkt_i),
        .req_ready_o  (req_ready_o),
        .cache_v_o    (cache_v_o),
        .cache_pkt_o  (cache_pkt_o),
        .cache_ready_i(cache_ready_i),
        .cache_v_i    (cache_v_i),
        .cache_data_i (cache_data_i),
        .cache_yumi_o (cache_yumi_o),
        .resp_v_o     (resp_v_o),
        .resp_data_o  (resp_data_o),
        .resp_yumi_i  (resp_yumi_i),
        .grant_count_o(grant_count_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int rr_m = 0;
    int idq[$];
    int gcnt[N];

    // Snapshot of DUT outputs from the most recent cycle
    logic [N-1:0]    obs_ready;
    logic [N-1:0]    obs_resp_v;
    logic            obs_cache_v;
    logic            obs_yumi;
    logic [DW-1:0]   obs_data;
    logic [N*32-1:0] obs_gc;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, compare outputs shortly
    // after, then advance the model at the rising edge.
    task automatic applyStimulus(input logic [N-1:0] rv, input logic cr, input logic cv,
                                 input logic [DW-1:0] cd, input logic [N-1:0] ry,
                                 input logic rst);
        int win;
        int head;
        logic [N-1:0]    e_ready;
        logic [N-1:0]    e_resp_v;
        logic            e_yumi;
        logic [N*32-1:0] e_gc;
        @(negedge clk_i);
        reset_i = rst;
        req_v_i = rv;
        for (int k = 0; k < N; k++) begin
            req_pkt_i[k*PW +: PW] = {$urandom, $urandom};
        end
        cache_ready_i = cr;
        cache_v_i     = cv && (idq.size() != 0);
        cache_data_i  = cd;
        resp_yumi_i   = ry;
        #1;
        obs_ready   = req_ready_o;
        obs_resp_v  = resp_v_o;
        obs_cache_v = cache_v_o;
        obs_yumi    = cache_yumi_o;
        obs_data    = resp_data_o;
        obs_gc      = grant_count_o;

        win = -1;
        if (cr && (idq.size() < FE)) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (rr_m + i) % N;
                if (win < 0 && rv[k]) win = k;
            end
        end
        e_ready = '0;
        if (win >= 0) e_ready[win] = 1'b1;
        head     = -1;
        e_resp_v = '0;
        e_yumi   = 1'b0;
        if (cache_v_i && idq.size() > 0) begin
            head           = idq[0];
            e_resp_v[head] = 1'b1;
            e_yumi         = ry[head];
        end
        for (int k = 0; k < N; k++) begin
`ifdef VCACHE_REQ_ARBITER_STATS_EN
            e_gc[k*32 +: 32] = 32'(gcnt[k]);
`else
            e_gc[k*32 +: 32] = '0;
`endif
        end

        if (!rst) begin
            checkOutput("req_ready", req_ready_o, e_ready);
            checkOutput("cache_v", cache_v_o, win >= 0);
            if (win >= 0) checkOutput("cache_pkt", cache_pkt_o, req_pkt_i[win*PW +: PW]);
            checkOutput("resp_v", resp_v_o, e_resp_v);
            checkOutput("cache_yumi", cache_yumi_o, e_yumi);
            if (head >= 0) checkOutput("resp_data", resp_data_o, cd);
            checkOutput("grant_count", grant_count_o, e_gc);
        end

        @(posedge clk_i);
        if (rst) begin
            idq.delete();
            rr_m = 0;
            for (int k = 0; k < N; k++) gcnt[k] = 0;
        end else begin
            if (e_yumi) void'(idq.pop_front());
            if (win >= 0) begin
                idq.push_back(win);
                rr_m = (win + 1) % N;
                gcnt[win]++;
            end
        end
    endtask

    initial begin
        logic [3:0] exp_seq [6];
        logic [N*32-1:0] exp_gc6;
        reset_i       = 1'b1;
        req_v_i       = '0;
        req_pkt_i     = '0;
        cache_ready_i = 1'b0;
        cache_v_i     = 1'b0;
        cache_data_i  = '0;
        resp_yumi_i   = '0;
        for (int k = 0; k < N; k++) gcnt[k] = 0;

        // Reset and reset-state outputs
        applyStimulus(4'b0000, 1'b0, 1'b0, '0, 4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0, '0, 4'b0000, 1'b0);
        checkOutput("rst_ready", obs_ready, 4'b0000);
        checkOutput("rst_cache_v", obs_cache_v, 1'b0);
        checkOutput("rst_resp_v", obs_resp_v, 4'b0000);
        checkOutput("rst_gc", obs_gc, '0);

        // All requesters valid, responses returned one cycle after grant
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'b1111, 1'b1, 1'b1, $urandom, 4'b1111, 1'b0);
            checkOutput("rr_grant", obs_ready, exp_seq[c]);
            if (c > 0) checkOutput("rr_route", obs_resp_v, exp_seq[c-1]);
        end
        applyStimulus(4'b0000, 1'b1, 1'b1, $urandom, 4'b1111, 1'b0);
        checkOutput("rr_route_last", obs_resp_v, 4'b0010);
`ifdef VCACHE_REQ_ARBITER_STATS_EN
        exp_gc6 = {32'd1, 32'd1, 32'd2, 32'd2};
        checkOutput("gc_after6", obs_gc, exp_gc6);
`endif

        // Only requester 2, cache silent: FIFO fills after 4 grants
        for (int c = 0; c < 4; c++) begin
            applyStimulus(4'b0100, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
            checkOutput("fill_grant", obs_ready, 4'b0100);
        end
        applyStimulus(4'b0100, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
        checkOutput("full_no_grant", obs_ready, 4'b0000);
        applyStimulus(4'b0100, 1'b1, 1'b1, 32'h1234, 4'b0100, 1'b0);
        checkOutput("full_pop_no_grant", obs_ready, 4'b0000);
        checkOutput("full_pop_yumi", obs_yumi, 1'b1);
        applyStimulus(4'b0100, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
        checkOutput("refill_grant", obs_ready, 4'b0100);

        // Full FIFO, pop and requester 1 valid same cycle
        applyStimulus(4'b0010, 1'b1, 1'b1, 32'h5678, 4'b0100, 1'b0);
        checkOutput("full_req1_no_grant", obs_ready, 4'b0000);
        applyStimulus(4'b0010, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
        checkOutput("full_req1_grant", obs_ready, 4'b0010);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(4'b0000, 1'b1, 1'b1, $urandom, 4'b1111, 1'b0);
        end

        // Issue order 3,0,1 and back-pressured responses
        applyStimulus(4'b1000, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
        checkOutput("ord_grant3", obs_ready, 4'b1000);
        applyStimulus(4'b0001, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
        checkOutput("ord_grant0", obs_ready, 4'b0001);
        applyStimulus(4'b0010, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
        checkOutput("ord_grant1", obs_ready, 4'b0010);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0000, 1'b1, 1'b1, 32'hA, 4'b0111, 1'b0);
            checkOutput("hold_resp_v", obs_resp_v, 4'b1000);
            checkOutput("hold_data", obs_data, 32'hA);
            checkOutput("hold_yumi", obs_yumi, 1'b0);
        end
        applyStimulus(4'b0000, 1'b1, 1'b1, 32'hA, 4'b1000, 1'b0);
        checkOutput("release_yumi", obs_yumi, 1'b1);
        applyStimulus(4'b0000, 1'b1, 1'b1, 32'hB, 4'b0001, 1'b0);
        checkOutput("route_b", obs_resp_v, 4'b0001);
        checkOutput("route_b_data", obs_data, 32'hB);
        applyStimulus(4'b0000, 1'b1, 1'b1, 32'hC, 4'b0010, 1'b0);
        checkOutput("route_c", obs_resp_v, 4'b0010);
        checkOutput("route_c_data", obs_data, 32'hC);

        // Cache not ready: no grant, pointer holds at 2
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b1111, 1'b0, 1'b0, '0, 4'b0000, 1'b0);
            checkOutput("stall_ready", obs_ready, 4'b0000);
            checkOutput("stall_cache_v", obs_cache_v, 1'b0);
        end
        applyStimulus(4'b1111, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
        checkOutput("stall_release", obs_ready, 4'b0100);

        // Reset mid-stream with 3 outstanding
        applyStimulus(4'b1111, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, '0, 4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1, 1'b0, '0, 4'b1111, 1'b0);
        checkOutput("mid_rst_ready", obs_ready, 4'b0000);
        checkOutput("mid_rst_cache_v", obs_cache_v, 1'b0);
        checkOutput("mid_rst_resp_v", obs_resp_v, 4'b0000);
        checkOutput("mid_rst_yumi", obs_yumi, 1'b0);
        checkOutput("mid_rst_gc", obs_gc, '0);
        applyStimulus(4'b1111, 1'b1, 1'b0, '0, 4'b0000, 1'b0);
        checkOutput("post_rst_grant", obs_ready, 4'b0001);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            applyStimulus(4'($urandom), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom, 4'($urandom), $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
